ifetch_unit: RTL and testbench

//  Instruction fetch stage directly upstream of the 3-bit-opcode main control decoder.

---
 rtl/ifetch_unit.sv | 124 ++++++++++++
 tb/tb_ifetch_unit.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: PC, req/ack fetch from imem, IR with opcode tap, branch/jump redirect.
// Optional macro HALT_OPCODE_EN: consuming opcode 3'b111 parks the unit in HALT until reset.
module ifetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               stall,
    input  logic               branch,
    input  logic               zero,
    input  logic [ADDR_W-1:0]  br_off,
    input  logic               jump,
    input  logic [ADDR_W-1:0]  j_target,
    output logic [INSTR_W-1:0] ir,
    output logic [2:0]         opcode,
    output logic               ir_valid,
    output logic [ADDR_W-1:0]  pc,
    output logic               halted
);

`ifdef HALT_OPCODE_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_VALID = 2'd2,
        S_HALT  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_VALID = 2'd2
    } state_t;
`endif

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0]   ir_q, ir_d;
    logic                 ir_valid_q, ir_valid_d;
    logic [ADDR_W-1:0]    next_pc;

    // Redirect target; only meaningful on the consume edge. Jump wins over branch.
    always_comb begin
        next_pc = pc_q + ADDR_W'(1);
        if (jump) begin
            next_pc = j_target;
        end else if (branch && zero) begin
            next_pc = pc_q + ADDR_W'(1) + br_off;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        case (state_q)
            S_IDLE: begin
                ir_valid_d = 1'b0;
                state_d    = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    ir_d       = imem_data;
                    ir_valid_d = 1'b1;
                    state_d    = S_VALID;
                end
            end
            S_VALID: begin
                if (!stall) begin
                    ir_valid_d = 1'b0;
`ifdef HALT_OPCODE_EN
                    if (ir_q[INSTR_W-1 -: 3] == 3'b111) begin
                        state_d = S_HALT;
                    end else begin
                        pc_d    = next_pc;
                        state_d = S_FETCH;
                    end
`else
                    pc_d    = next_pc;
                    state_d = S_FETCH;
`endif
                end
            end
            default: begin
                // HALT (when present) is sticky; only reset leaves it.
                ir_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
        end
    end

    assign imem_req  = (state_q == S_FETCH);
    assign imem_addr = pc_q;
    assign ir        = ir_q;
    assign opcode    = ir_q[INSTR_W-1 -: 3];
    assign ir_valid  = ir_valid_q;
    assign pc        = pc_q;
`ifdef HALT_OPCODE_EN
    assign halted    = (state_q == S_HALT);
`else
    assign halted    = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: stimulus pushes expected fetch addresses and IR contents,
// a monitor pops them when the DUT raises imem_req or ir_valid.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_data = 16'h0000;
    logic        stall;
    logic        branch;
    logic        zero;
    logic [7:0]  br_off;
    logic        jump;
    logic [7:0]  j_target;
    logic [15:0] ir;
    logic [2:0]  opcode;
    logic        ir_valid;
    logic [7:0]  pc;
    logic        halted;

    typedef struct {
        logic [15:0] ir;
        logic [7:0]  pc;
    } exp_t;

    int          tests = 0;
    int          fails = 0;
    logic [15:0] mem [0:255];
    bit          ack_en = 1'b0;
    bit          force_ack = 1'b0;
    logic [7:0]  exp_addr_q [$];
    exp_t        exp_ir_q [$];
    logic        prev_req = 1'b0;
    logic        prev_valid = 1'b0;
    exp_t        mon_e;
    logic [7:0]  mon_a;

    always #5 clk = ~clk;

    ifetch_unit dut (
        .clk       (clk),
        .rst       (rst),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .stall     (stall),
        .branch    (branch),
        .zero      (zero),
        .br_off    (br_off),
        .jump      (jump),
        .j_target  (j_target),
        .ir        (ir),
        .opcode    (opcode),
        .ir_valid  (ir_valid),
        .pc        (pc),
        .halted    (halted)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end else begin
            $display("[TB] ok %s = %h", name, act);
        end
    endtask

    task automatic push_addr(input logic [7:0] a);
        exp_addr_q.push_back(a);
    endtask

    task automatic push_ir(input logic [7:0] a);
        exp_t e;
        e.ir = mem[a];
        e.pc = a;
        exp_ir_q.push_back(e);
    endtask

    task automatic push_fetch(input logic [7:0] a);
        push_addr(a);
        push_ir(a);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (ir_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (ir_valid !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL wait_valid: ir_valid=%b after 50 cycles, required 1", ir_valid);
        end
    endtask

    // One consume edge with the given redirect inputs; redirect inputs are scrambled afterwards.
    task automatic consume(input logic br, input logic z, input logic [7:0] off,
                           input logic j, input logic [7:0] tgt);
        wait_valid();
        branch   = br;
        zero     = z;
        br_off   = off;
        jump     = j;
        j_target = tgt;
        stall    = 1'b0;
        @(negedge clk);
        stall    = 1'b1;
        branch   = 1'($urandom);
        zero     = 1'($urandom);
        br_off   = 8'($urandom);
        jump     = 1'($urandom);
        j_target = 8'($urandom);
        check("ir_valid_drop", 32'(ir_valid), 32'h0);
    endtask

    // Memory model: acks any outstanding request while enabled, settled 1 time unit after negedge.
    always @(negedge clk) begin
        #1;
        imem_ack  = force_ack || (imem_req && ack_en);
        imem_data = force_ack ? 16'hABCD : mem[imem_addr];
    end

    always @(negedge clk) begin
        if (imem_req === 1'b1 && !prev_req) begin
            if (exp_addr_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_req: addr %h, no request expected", imem_addr);
            end else begin
                mon_a = exp_addr_q.pop_front();
                check("fetch_addr", 32'(imem_addr), 32'(mon_a));
            end
        end
        if (ir_valid === 1'b1 && !prev_valid) begin
            if (exp_ir_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_ir: ir %h pc %h, none expected", ir, pc);
            end else begin
                mon_e = exp_ir_q.pop_front();
                check("ir", 32'(ir), 32'(mon_e.ir));
                check("ir_pc", 32'(pc), 32'(mon_e.pc));
                check("opcode", 32'(opcode), 32'(mon_e.ir[15:13]));
            end
        end
        prev_req   <= (imem_req === 1'b1);
        prev_valid <= (ir_valid === 1'b1);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, required $finish earlier");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h00] = 16'h2000;
        mem[8'h01] = 16'h4000;
        mem[8'h02] = 16'h6001;
        mem[8'h03] = 16'h0003;
        mem[8'h04] = 16'h0004;
        mem[8'h05] = 16'h0005;
        mem[8'h06] = 16'h8006;
        mem[8'h40] = 16'hA040;
        mem[8'hFF] = 16'hC0FF;
        mem[8'h80] = 16'hE000;
        mem[8'h81] = 16'h0081;

        rst = 1'b1; stall = 1'b1; branch = 1'b0; zero = 1'b0;
        br_off = 8'h00; jump = 1'b0; j_target = 8'h00;

        // Reset
        repeat (2) @(negedge clk);
        check("rst_pc", 32'(pc), 32'h00);
        check("rst_ir_valid", 32'(ir_valid), 32'h0);
        check("rst_imem_req", 32'(imem_req), 32'h0);
        check("rst_ir", 32'(ir), 32'h0000);
        check("rst_halted", 32'(halted), 32'h0);
        push_fetch(8'h00);
        rst = 1'b0;
        @(negedge clk);
        check("first_req", 32'(imem_req), 32'h1);
        ack_en = 1'b1;

        // Sequential
        push_fetch(8'h01);
        consume(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        push_fetch(8'h02);
        consume(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);

        // Stall for 3 cycles at pc 0x02
        wait_valid();
        repeat (3) begin
            @(negedge clk);
            check("stall_ir", 32'(ir), 32'h6001);
            check("stall_pc", 32'(pc), 32'h02);
            check("stall_valid", 32'(ir_valid), 32'h1);
            check("stall_req", 32'(imem_req), 32'h0);
        end
        push_fetch(8'h03);
        consume(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        push_fetch(8'h04);
        consume(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        push_fetch(8'h05);
        consume(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);

        // Taken branch: 0x05 + 1 - 3 = 0x03
        push_fetch(8'h03);
        consume(1'b1, 1'b1, 8'hFD, 1'b0, 8'h00);
        push_fetch(8'h04);
        consume(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        push_fetch(8'h05);
        consume(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        // Untaken branch
        push_fetch(8'h06);
        consume(1'b1, 1'b0, 8'hFD, 1'b0, 8'h00);
        // Jump over a would-be-taken branch
        push_fetch(8'h40);
        consume(1'b1, 1'b1, 8'h10, 1'b1, 8'h40);
        push_fetch(8'hFF);
        consume(1'b0, 1'b0, 8'h00, 1'b1, 8'hFF);
        // Wrap 0xFF -> 0x00
        push_fetch(8'h00);
        consume(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        push_fetch(8'h80);
        consume(1'b0, 1'b0, 8'h00, 1'b1, 8'h80);

        // Opcode 3'b111 at 0x80
        wait_valid();
        ack_en = 1'b0;
`ifdef HALT_OPCODE_EN
        consume(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        repeat (3) begin
            @(negedge clk);
            check("halt_halted", 32'(halted), 32'h1);
            check("halt_req", 32'(imem_req), 32'h0);
            check("halt_pc", 32'(pc), 32'h80);
        end
`else
        push_addr(8'h81);
        consume(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        check("nohalt_halted", 32'(halted), 32'h0);
        check("nohalt_pc", 32'(pc), 32'h81);
        check("nohalt_req", 32'(imem_req), 32'h1);
`endif

        // Reset mid-fetch, then an ack landing in IDLE
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        push_addr(8'h00);
        @(negedge clk);
        check("refetch_req", 32'(imem_req), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check("midfetch_pc", 32'(pc), 32'h00);
        check("midfetch_valid", 32'(ir_valid), 32'h0);
        check("midfetch_req", 32'(imem_req), 32'h0);
        check("midfetch_halted", 32'(halted), 32'h0);
        rst = 1'b0;
        force_ack = 1'b1;
        push_addr(8'h00);
        @(negedge clk);
        force_ack = 1'b0;
        check("idle_ack_ir", 32'(ir), 32'h0000);
        check("idle_ack_valid", 32'(ir_valid), 32'h0);
        push_ir(8'h00);
        ack_en = 1'b1;
        wait_valid();
        repeat (2) @(negedge clk);
        check("addr_q_drained", 32'(exp_addr_q.size()), 32'h0);
        check("ir_q_drained", 32'(exp_ir_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
